// File: rtl/diferential_rvb1_pkg.sv
// Shared constants for the 8-bit RV32I-subset core: opcode/funct fields,
// the hardwired program image and the hex seven-segment table.
package diferential_rvb1_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam int ROM_WORDS = 16;

  // Counting loop: x1 counts 0..9 onto the display, then jumps back to 0.
  localparam logic [31:0] ROM [ROM_WORDS] = '{
    32'h00000093,  // addi x1,x0,0
    32'h00A00113,  // addi x2,x0,10
    32'h00102023,  // sw   x1,0(x0)
    32'h00108093,  // addi x1,x1,1
    32'hFE209CE3,  // bne  x1,x2,-8
    32'hFEDFF06F,  // jal  x0,-20
    32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013,
    32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013
  };

  localparam logic [6:0] SEG7_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/diferential_rvb1_seg7.sv
// Hex digit to active-high a..g segment decoder (bit0 = a), purely combinational.
module rvb1_seg7
  import diferential_rvb1_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segments
);

  assign segments = SEG7_LUT[digit];

endmodule

// File: rtl/diferential_rvb1.sv
// Single-cycle 8-bit RV32I-subset core running a fixed ROM program that
// counts 0..9 on a seven-segment display register.
module diferential_rvb1
  import diferential_rvb1_pkg::*;
(
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic       clk;
  logic       rst;
  logic [3:0] pc;
  logic [7:0] rf [4];
  logic [7:0] disp;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [1:0]  rd;
  logic [1:0]  rs1;
  logic [1:0]  rs2;
  logic [7:0]  rs1_val;
  logic [7:0]  rs2_val;
  logic [7:0]  imm_i;
  logic [3:0]  br_off;
  logic [3:0]  jal_off;
  logic [3:0]  pc_inc;

  logic [3:0]  pc_next;
  logic        rf_we;
  logic [7:0]  rf_wdata;
  logic        disp_we;
  logic [6:0]  segments;
  logic        unused_bits;

  assign clk = io_in[0];
  assign rst = io_in[1];

  assign instr   = ROM[pc];
  assign opcode  = instr[6:0];
  assign rd      = instr[8:7];
  assign funct3  = instr[14:12];
  assign rs1     = instr[16:15];
  assign rs2     = instr[21:20];
  assign funct7  = instr[31:25];
  assign imm_i   = instr[27:20];
  // Word offsets are byte offset bits [5:2]; higher bits vanish in the mod-16 add.
  assign br_off  = {instr[25], instr[11:9]};
  assign jal_off = instr[25:22];
  assign pc_inc  = pc + 4'd1;

  assign rs1_val = rf[rs1];
  assign rs2_val = rf[rs2];

  always_comb begin
    pc_next  = pc_inc;
    rf_we    = 1'b0;
    rf_wdata = '0;
    disp_we  = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (funct3 == F3_ADD) begin
          rf_we    = 1'b1;
          rf_wdata = rs1_val + imm_i;
        end
      end
      OP_REG: begin
        if (funct3 == F3_ADD && funct7 == F7_ADD) begin
          rf_we    = 1'b1;
          rf_wdata = rs1_val + rs2_val;
        end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
          rf_we    = 1'b1;
          rf_wdata = rs1_val - rs2_val;
        end
      end
      OP_BRANCH: begin
        if ((funct3 == F3_BEQ && rs1_val == rs2_val) ||
            (funct3 == F3_BNE && rs1_val != rs2_val))
          pc_next = pc + br_off;
      end
      OP_JAL: begin
        rf_we    = 1'b1;
        rf_wdata = {4'd0, pc_inc};
        pc_next  = pc + jal_off;
      end
      OP_STORE: begin
        if (funct3 == F3_SW)
          disp_we = 1'b1;
      end
      default: ;
    endcase
  end

  // x0 is reset like the others and never written, so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= '0;
      rf   <= '{default: '0};
      disp <= '0;
    end else begin
      pc <= pc_next;
      if (rf_we && rd != 2'd0)
        rf[rd] <= rf_wdata;
      if (disp_we)
        disp <= rs2_val;
    end
  end

  rvb1_seg7 u_seg7 (
    .digit    (disp[3:0]),
    .segments (segments)
  );

  assign io_out = {1'b0, segments};

  assign unused_bits = ^{io_in[7:2], disp[7:4], instr};

endmodule

// File: tb/tb_diferential_rvb1.sv
// Directed bench: async reset, digit timing of the counting program,
// mid-run reset, and an exhaustive check of the segment decoder.
module tb_diferential_rvb1;

  logic       clk;
  logic       rst;
  logic [5:0] spare;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic [3:0] u_digit;
  logic [6:0] u_segments;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;

  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  assign io_in = {spare, rst, clk};

  diferential_rvb1 dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  rvb1_seg7 u_seg (
    .digit    (u_digit),
    .segments (u_segments)
  );

  // Hand-traced program: first sw lands on edge 3, the loop body is 3 edges,
  // and 9 stays up for 6 edges while x1 hits 10, jal returns and the
  // counter is reinitialised, so the pattern repeats every 33 edges.
  function automatic logic [3:0] digit_at(input int e);
    int k;
    if (e < 3) return 4'd0;
    k = (e - 3) % 33;
    if (k < 30) return 4'(k / 3);
    return 4'd9;
  endfunction

  function automatic logic [7:0] exp_out(input int e);
    return {1'b0, seg_tab[digit_at(e)]};
  endfunction

  task automatic tick();
    clk = 1'b1;
    #5;
    clk = 1'b0;
    #5;
    edge_cnt++;
  endtask

  task automatic run_edges(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_cnt);
      $error("check %s", tag);
    end
  endtask

  task automatic check_restart();
    run_edges(3);
    check("after_e3", io_out, 8'h3F);
    run_edges(3);
    check("after_e6", io_out, 8'h06);
    run_edges(3);
    check("after_e9", io_out, 8'h5B);
  endtask

  initial begin
    clk     = 1'b0;
    rst     = 1'b0;
    spare   = 6'h2A;
    u_digit = 4'd0;
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", io_out, 8'h3F);

    run_edges(2);
    check("reset_held_clocked", io_out, 8'h3F);

    rst = 1'b0;
    #2;
    edge_cnt = 0;
    check_restart();

    run_edges(30 - edge_cnt);
    check("digit9_e30", io_out, 8'h6F);
    for (int e = 31; e <= 35; e++) begin
      tick();
      check("digit9_hold", io_out, 8'h6F);
    end
    tick();
    check("wrap_e36", io_out, 8'h3F);
    run_edges(3);
    check("second_one_e39", io_out, 8'h06);

    for (int i = 0; i < 200; i++) begin
      spare = 6'($urandom_range(0, 63));
      tick();
      check("long_run", io_out, exp_out(edge_cnt));
      check("bit7_zero", {7'd0, io_out[7]}, 8'd0);
    end

    begin
      int budget;
      budget = 0;
      while (digit_at(edge_cnt) != 4'd7 && budget < 40) begin
        tick();
        budget++;
      end
      check("reach_digit7_budget", (budget < 40) ? 8'd1 : 8'd0, 8'd1);
    end
    check("digit7_shown", io_out, 8'h07);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_async_reset", io_out, 8'h3F);
    #2;
    rst = 1'b0;
    #2;
    edge_cnt = 0;
    check_restart();
    for (int i = 0; i < 40; i++) begin
      tick();
      check("post_reset_run", io_out, exp_out(edge_cnt));
    end

    for (int d = 0; d < 16; d++) begin
      u_digit = 4'(d);
      #1;
      check("seg7_unit", {1'b0, u_segments}, {1'b0, seg_tab[d]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
